data_island_scheduler: RTL and testbench
========================================

DATA_ISLAND_SCHEDULER -- requirements
Module: data_island_scheduler

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 858: total pixels per line, including blanking.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 525: total lines per frame.
REQ-003 SHALL have parameter SCREEN_WIDTH, default 720: active pixels per line; active area is cx < SCREEN_WIDTH.
REQ-004 SHALL have parameter MAX_PACKETS, default 18: maximum packets per data island (range 1..18).
REQ-005 SHALL have port clk_pixel  in  1: pixel clock, the only clock.
REQ-006 SHALL have port reset  in  1: reset, synchronous and active-high.
REQ-007 SHALL have port enable  in  1: permits new data islands to start.
REQ-008 SHALL have port cx  in  12: current pixel column, 0..FRAME_WIDTH-1.
REQ-009 SHALL have port cy  in  11: current line, 0..FRAME_HEIGHT-1.
REQ-010 SHALL have port mode  out  2: period type; 0 CTRL, 1 PREAMBLE, 2 GUARD, 3 DATA.
REQ-011 SHALL have port packet_enable  out  1: one-cycle pulse, issued one cycle before each packet's first pixel.
REQ-012 SHALL have port packet_pixel_counter  out  5: pixel index within the current packet, 0..31.
REQ-013 SHALL have port packet_index  out  5: index of the current packet within the island.
REQ-014 SHALL have port video_field_end  out  1: one-cycle pulse on the last pixel of the frame.

Function
REQ-015 SHALL fix the packet count at elaboration: N = min(MAX_PACKETS, (FRAME_WIDTH-SCREEN_WIDTH-30)/32), using integer floor division.
REQ-016 SHALL never start an island when N < 1; all outputs then stay at reset values, except video_field_end.
REQ-017 SHALL register all outputs; each output value at cycle t+1 corresponds to the cx/cy sampled at cycle t (1-cycle latency).
REQ-018 SHALL use a state machine with states IDLE, PREAMBLE, LEAD_GB, PACKET, TRAIL_GB.
REQ-019 SHALL leave IDLE only when cx == IS (IS = SCREEN_WIDTH+4) and enable == 1; this applies on every line, including vertical blanking lines.
REQ-020 SHALL, once started, sequence the island from an internal counter, independent of cx:
- PREAMBLE: 8 cycles, mode=1.
- LEAD_GB: 2 cycles, mode=2.
- PACKET: 32*N cycles, mode=3.
- TRAIL_GB: 2 cycles, mode=2.
- then return to IDLE, mode=0.
REQ-021 SHALL make the total island length 12+32N cycles, ending at least 4 CTRL cycles before cx = FRAME_WIDTH-10 (the video preamble).
REQ-022 SHALL drive packet_pixel_counter through 0..31 in PACKET state and wrap 31 -> 0 at each packet boundary; it is 0 outside PACKET.
REQ-023 SHALL increment packet_index at each 31 -> 0 wrap, starting from 0 and ending at N-1; it is 0 outside PACKET.
REQ-024 SHALL assert packet_enable exactly N times per island:
- on the last LEAD_GB cycle;
- on each PACKET cycle where packet_pixel_counter == 31 and packet_index < N-1;
- never on the final packet's cycle 31.
REQ-025 SHALL complete an island already in progress when enable is deasserted; no new island starts while enable == 0.
REQ-026 SHALL assert video_field_end for exactly one cycle, corresponding to cx == FRAME_WIDTH-1 and cy == FRAME_HEIGHT-1, independent of enable and island state.
REQ-027 SHALL ignore a cx == IS match while not in IDLE, so islands never overlap.

Reset
REQ-028 SHALL, in the cycle after reset is sampled high, drive:
- state IDLE;
- mode = 0;
- packet_enable = 0;
- packet_pixel_counter = 0;
- packet_index = 0;
- video_field_end = 0.
REQ-029 SHALL abandon any island in progress when reset is asserted mid-island, with no partial guard band; the next island starts at the next cx == IS seen with enable == 1 after reset is released.

Verification
REQ-030 SHALL cover default parameters (N = 3, IS = 724), enable = 1: mode=1 for cx 724..731, 2 for 732..733, 3 for 734..829, 2 for 830..831, 0 for 832..857; packet_enable pulses for cx 733, 765, 797.
REQ-031 SHALL cover FRAME_WIDTH=800, SCREEN_WIDTH=640: N = 4; island occupies cx 644..783; exactly 4 packet_enable pulses; packet_index reaches 3.
REQ-032 SHALL cover FRAME_WIDTH=760, SCREEN_WIDTH=720: N = 0; mode stays 0 for a whole frame; packet_enable never pulses.
REQ-033 SHALL cover reset asserted at cx = 750 (mid-PACKET): the next cycle has mode=0 and counters 0; after release, the next island starts at the following line's cx = 724.
REQ-034 SHALL cover enable dropped at cx = 740: the current island completes through cx 831; the next line has no island (mode=0 throughout).
REQ-035 SHALL cover cx = 857, cy = 524: video_field_end high for exactly one cycle, and no other pulse within the frame.

Source files
------------

// File: rtl/data_island_scheduler.sv
// Data-island scheduler: once per line, after the active area, sequences preamble, leading
// guard band, N 32-pixel packets and trailing guard band. Also flags the frame's last pixel.
module data_island_scheduler #(
   parameter int FRAME_WIDTH  = 858,
   parameter int FRAME_HEIGHT = 525,
   parameter int SCREEN_WIDTH = 720,
   parameter int MAX_PACKETS  = 18
) (
   input  logic        clk_pixel,
   input  logic        reset,
   input  logic        enable,
   input  logic [11:0] cx,
   input  logic [10:0] cy,
   output logic [1:0]  mode,
   output logic        packet_enable,
   output logic [4:0]  packet_pixel_counter,
   output logic [4:0]  packet_index,
   output logic        video_field_end
);

   // Packets that fit in horizontal blanking, leaving room for the island overhead
   // and the video preamble that precedes the next active line.
   localparam int N_FIT      = (FRAME_WIDTH - SCREEN_WIDTH - 30) / 32;
   localparam int N          = (MAX_PACKETS < N_FIT) ? MAX_PACKETS : N_FIT;
   localparam bit HAS_ISLAND = (N >= 1);

   localparam logic [11:0] IS_CX    = 12'(SCREEN_WIDTH + 4);
   localparam logic [11:0] LAST_CX  = 12'(FRAME_WIDTH - 1);
   localparam logic [10:0] LAST_CY  = 11'(FRAME_HEIGHT - 1);
   localparam logic [9:0]  PKT_LAST = HAS_ISLAND ? 10'(32 * N - 1) : 10'd0;
   localparam logic [4:0]  LAST_IDX = HAS_ISLAND ? 5'(N - 1) : 5'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_LEAD_GB,
      S_PACKET,
      S_TRAIL_GB
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [9:0] r_cnt;
   logic [9:0] w_cnt_nxt;

   logic [1:0] w_mode_nxt;
   logic       w_pe_nxt;
   logic [4:0] w_ppc_nxt;
   logic [4:0] w_pidx_nxt;
   logic       w_vfe_nxt;
   logic       w_in_pkt;

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         r_state              <= S_IDLE;
         r_cnt                <= '0;
         mode                 <= 2'd0;
         packet_enable        <= 1'b0;
         packet_pixel_counter <= '0;
         packet_index         <= '0;
         video_field_end      <= 1'b0;
      end else begin
         r_state              <= w_state_nxt;
         r_cnt                <= w_cnt_nxt;
         mode                 <= w_mode_nxt;
         packet_enable        <= w_pe_nxt;
         packet_pixel_counter <= w_ppc_nxt;
         packet_index         <= w_pidx_nxt;
         video_field_end      <= w_vfe_nxt;
      end
   end

   // r_cnt counts cycles within the current phase; cx only matters for the start in IDLE,
   // so a cx match mid-island is ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 10'd1;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (HAS_ISLAND && enable && (cx == IS_CX))
               w_state_nxt = S_PREAMBLE;
         end
         S_PREAMBLE: begin
            if (r_cnt == 10'd7) begin
               w_state_nxt = S_LEAD_GB;
               w_cnt_nxt   = '0;
            end
         end
         S_LEAD_GB: begin
            if (r_cnt == 10'd1) begin
               w_state_nxt = S_PACKET;
               w_cnt_nxt   = '0;
            end
         end
         S_PACKET: begin
            if (r_cnt == PKT_LAST) begin
               w_state_nxt = S_TRAIL_GB;
               w_cnt_nxt   = '0;
            end
         end
         S_TRAIL_GB: begin
            if (r_cnt == 10'd1) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      w_mode_nxt = 2'd0;
      case (w_state_nxt)
         S_PREAMBLE:            w_mode_nxt = 2'd1;
         S_LEAD_GB, S_TRAIL_GB: w_mode_nxt = 2'd2;
         S_PACKET:              w_mode_nxt = 2'd3;
         default:               w_mode_nxt = 2'd0;
      endcase
      w_in_pkt   = (w_state_nxt == S_PACKET);
      w_ppc_nxt  = w_in_pkt ? w_cnt_nxt[4:0] : 5'd0;
      w_pidx_nxt = w_in_pkt ? w_cnt_nxt[9:5] : 5'd0;
      // Pulse one cycle ahead of each packet's first pixel; none after the final packet.
      w_pe_nxt   = ((w_state_nxt == S_LEAD_GB) && (w_cnt_nxt == 10'd1)) ||
                   (w_in_pkt && (w_cnt_nxt[4:0] == 5'd31) && (w_cnt_nxt[9:5] < LAST_IDX));
      w_vfe_nxt  = (cx == LAST_CX) && (cy == LAST_CY);
   end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Scoreboard bench: stimulus pushes hand-derived expected outputs per driven pixel,
// a negedge monitor pops and compares them one cycle later across three parameterizations.
module tb_data_island_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst[3];
   logic        en[3];
   logic [11:0] cx[3];
   logic [10:0] cy[3];
   logic [1:0]  mode[3];
   logic        pe[3];
   logic [4:0]  ppc[3];
   logic [4:0]  pidx[3];
   logic        vfe[3];

   // Hand-computed per configuration: frame width/height, packet count.
   int fw_of[3] = '{858, 800, 760};
   int fh_of[3] = '{525, 4, 4};
   int n_of[3]  = '{3, 4, 0};

   data_island_scheduler u0 (
      .clk_pixel(clk), .reset(rst[0]), .enable(en[0]), .cx(cx[0]), .cy(cy[0]),
      .mode(mode[0]), .packet_enable(pe[0]), .packet_pixel_counter(ppc[0]),
      .packet_index(pidx[0]), .video_field_end(vfe[0]));

   data_island_scheduler #(.FRAME_WIDTH(800), .FRAME_HEIGHT(4), .SCREEN_WIDTH(640)) u1 (
      .clk_pixel(clk), .reset(rst[1]), .enable(en[1]), .cx(cx[1]), .cy(cy[1]),
      .mode(mode[1]), .packet_enable(pe[1]), .packet_pixel_counter(ppc[1]),
      .packet_index(pidx[1]), .video_field_end(vfe[1]));

   data_island_scheduler #(.FRAME_WIDTH(760), .FRAME_HEIGHT(4), .SCREEN_WIDTH(720)) u2 (
      .clk_pixel(clk), .reset(rst[2]), .enable(en[2]), .cx(cx[2]), .cy(cy[2]),
      .mode(mode[2]), .packet_enable(pe[2]), .packet_pixel_counter(ppc[2]),
      .packet_index(pidx[2]), .video_field_end(vfe[2]));

   typedef struct {
      int         d;
      int         x;
      int         y;
      logic [1:0] mode;
      logic       pe;
      logic [4:0] ppc;
      logic [4:0] pidx;
      logic       vfe;
      time        t;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   time  t_pos = 0;

   // Expected outputs for pixel x of line y, island starting at cx=start (-1: no island).
   function automatic exp_t model(int d, int x, int y, int start);
      exp_t e;
      int   o;
      int   n;
      n      = n_of[d];
      e.d    = d;
      e.x    = x;
      e.y    = y;
      e.mode = 2'd0;
      e.pe   = 1'b0;
      e.ppc  = 5'd0;
      e.pidx = 5'd0;
      e.t    = 0;
      e.vfe  = (x == fw_of[d] - 1) && (y == fh_of[d] - 1);
      if (start >= 0 && x >= start) begin
         o = x - start;
         if (o < 8) e.mode = 2'd1;
         else if (o < 10) begin
            e.mode = 2'd2;
            e.pe   = (o == 9);
         end else if (o < 10 + 32 * n) begin
            e.mode = 2'd3;
            e.ppc  = 5'((o - 10) % 32);
            e.pidx = 5'((o - 10) / 32);
            e.pe   = (((o - 10) % 32) == 31) && (((o - 10) / 32) < n - 1);
         end else if (o < 12 + 32 * n) e.mode = 2'd2;
      end
      return e;
   endfunction

   task automatic step(input int d, input int x, input int y, input logic e_en,
                       input logic e_rst, input exp_t e);
      @(posedge clk);
      #1;
      cx[d]  = 12'(x);
      cy[d]  = 11'(y);
      en[d]  = e_en;
      rst[d] = e_rst;
      e.t    = $time;
      sbq.push_back(e);
   endtask

   task automatic reset_dut(input int d);
      exp_t e;
      e = model(d, 0, 0, -1);
      step(d, 0, 0, 1'b1, 1'b1, e);
      step(d, 0, 0, 1'b1, 1'b1, e);
   endtask

   // One full line; optional enable drop from drop_at and one-cycle reset at rst_at.
   task automatic run_line(input int d, input int y, input logic en0, input int start,
                           input int drop_at, input int rst_at);
      exp_t e;
      logic e_en;
      logic e_rs;
      for (int x = 0; x < fw_of[d]; x++) begin
         e_en = en0 && !(drop_at >= 0 && x >= drop_at);
         e_rs = (x == rst_at);
         if (e_rs) begin
            e     = model(d, x, y, -1);
            e.vfe = 1'b0;
         end else begin
            e = model(d, x, y, (rst_at >= 0 && x > rst_at) ? -1 : start);
         end
         step(d, x, y, e_en, e_rs, e);
      end
   endtask

   always @(posedge clk) t_pos = $time;

   always @(negedge clk) begin
      exp_t       e;
      logic [13:0] act;
      logic [13:0] req;
      while (sbq.size() > 0 && sbq[0].t < t_pos) begin
         e   = sbq.pop_front();
         act = {mode[e.d], pe[e.d], ppc[e.d], pidx[e.d], vfe[e.d]};
         req = {e.mode, e.pe, e.ppc, e.pidx, e.vfe};
         n_cmp++;
         if (act !== req) begin
            n_bad++;
            $display("FAIL dut%0d cy=%0d cx=%0d: got mode=%0d pe=%0b ppc=%0d idx=%0d vfe=%0b, want mode=%0d pe=%0b ppc=%0d idx=%0d vfe=%0b",
                     e.d, e.y, e.x, mode[e.d], pe[e.d], ppc[e.d], pidx[e.d], vfe[e.d],
                     e.mode, e.pe, e.ppc, e.pidx, e.vfe);
         end
      end
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1;
         en[d]  = 1'b0;
         cx[d]  = '0;
         cy[d]  = '0;
      end

      // Default timing: N=3, island at cx 724..835-4.
      reset_dut(0);
      run_line(0, 0, 1'b1, 724, -1, -1);
      run_line(0, 1, 1'b1, 724, -1, -1);
      // Enable dropped mid-island: finishes, next line stays CTRL.
      run_line(0, 2, 1'b1, 724, 740, -1);
      run_line(0, 3, 1'b0, -1, -1, -1);
      // Reset mid-packet abandons the island; next line starts cleanly.
      run_line(0, 4, 1'b1, 724, -1, 750);
      run_line(0, 5, 1'b1, 724, -1, -1);
      // Frame end pulse only on cy=524, cx=857.
      run_line(0, 523, 1'b1, 724, -1, -1);
      run_line(0, 524, 1'b1, 724, -1, -1);
      run_line(0, 0, 1'b1, 724, -1, -1);

      // 800/640: N=4, island cx 644..783.
      reset_dut(1);
      for (int y = 0; y < 4; y++) run_line(1, y, 1'b1, 644, -1, -1);

      // 760/720: N=0, never an island.
      reset_dut(2);
      for (int y = 0; y < 4; y++) run_line(2, y, 1'b1, -1, -1, -1);

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      if (sbq.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, want 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
